// File: rtl/opl3_pkg.sv
// ---------------------------------------------------------------------------
// opl3_pkg
// Shared types for the OPL3 register-write path.
//   opl3_reg_wr_t  : one register write (valid strobe + bank/address/data)
//   NUM_REG_WR_REQ : default number of requesters feeding the arbiter
//   rr_next_idx    : round-robin successor of an index, wrapping at n
// ---------------------------------------------------------------------------
package opl3_pkg;

    localparam int NUM_REG_WR_REQ = 2;

    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;

    function automatic int unsigned rr_next_idx(input int unsigned idx,
                                                input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/opl3_rr_arb.sv
// ---------------------------------------------------------------------------
// opl3_rr_arb
// Round-robin winner selection with a registered priority pointer.
// The winner is the first set bit of i_valid found scanning upward from the
// pointer, wrapping NUM_REQ-1 -> 0. When i_advance is strobed the pointer
// moves to the slot just after the current winner; otherwise it holds.
//
// Ports
//   clk       in   clock, all state on posedge
//   reset     in   synchronous active-high reset (pointer -> 0)
//   i_valid   in   [NUM_REQ] request-valid vector
//   i_advance in   winner was accepted this cycle
//   o_grant   out  [NUM_REQ] one-hot (or zero) winner, combinational
//   o_ptr     out  current round-robin pointer
// ---------------------------------------------------------------------------
module opl3_rr_arb
    import opl3_pkg::*;
#(
    parameter int NUM_REQ = NUM_REG_WR_REQ
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         i_valid,
    input  logic                       i_advance,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_ptr
);

    localparam int PW = $clog2(NUM_REQ);
    // one extra bit so ptr+offset cannot overflow before the modulo fold
    localparam int SW = PW + 1;

    logic [PW-1:0] r_ptr;
    logic [SW-1:0] w_sum;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_win_idx;
    logic          w_found;

    always_comb begin
        o_grant   = '0;
        w_sum     = '0;
        w_idx     = '0;
        w_win_idx = '0;
        w_found   = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_sum = SW'(r_ptr) + SW'(off);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_found && i_valid[w_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_idx;
            end
        end
        if (w_found) begin
            o_grant[w_win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= PW'(rr_next_idx(32'(w_win_idx), NUM_REQ));
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/opl3_reg_wr_arbiter.sv
// ---------------------------------------------------------------------------
// opl3_reg_wr_arbiter
// Merges NUM_REQ register-write streams into one paced write stream for the
// OPL3 register file. Requesters are served round-robin; after each accepted
// write a gap counter blocks further acceptances so that successive output
// pulses are at least MIN_GAP_CYCLES clocks apart.
//
// Ports
//   clk          in   clock, all state on posedge
//   reset        in   synchronous active-high reset
//   req_wr       in   [NUM_REQ] per-requester write (valid + payload)
//   req_ready    out  [NUM_REQ] accept; transfer when valid && ready
//   opl3_reg_wr  out  registered write, .valid is a one-cycle pulse,
//                     payload holds its last value between pulses
//   idle         out  no write in flight and gap counter at zero
// ---------------------------------------------------------------------------
module opl3_reg_wr_arbiter
    import opl3_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REG_WR_REQ,
    parameter int MIN_GAP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  opl3_reg_wr_t       req_wr [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output opl3_reg_wr_t       opl3_reg_wr,
    output logic               idle
);

    localparam int CW = $clog2(MIN_GAP_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD = CW'(MIN_GAP_CYCLES - 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_GAP  = 1'b1;

    logic                       r_state;
    logic [CW-1:0]              r_gap_cnt;
    opl3_reg_wr_t               r_out;

    logic [NUM_REQ-1:0]         w_valid;
    logic [NUM_REQ-1:0]         w_grant;
    logic [$clog2(NUM_REQ)-1:0] w_unused_rr_ptr;
    logic                       w_accept;
    opl3_reg_wr_t               w_sel;

    always_comb begin
        w_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_valid[i] = req_wr[i].valid;
        end
    end

    // pointer output is only of interest for observation at this level
    opl3_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (w_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant),
        .o_ptr     (w_unused_rr_ptr)
    );

    // the grant is already qualified by valid, so only pacing and reset gate it
    assign req_ready = (r_state == ST_IDLE && !reset) ? w_grant : '0;
    assign w_accept  = |req_ready;

    // payload only reaches registers, never an output, through this mux;
    // the winner's .valid is 1 by construction of the grant
    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel = req_wr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_out     <= '0;
        end else begin
            r_out.valid <= 1'b0;
            if (w_accept) begin
                r_out     <= w_sel;
                r_gap_cnt <= GAP_LOAD;
                r_state   <= ST_GAP;
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
                if (r_gap_cnt == CW'(1)) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign opl3_reg_wr = r_out;
    assign idle        = (r_gap_cnt == '0) && !r_out.valid;

endmodule

// File: tb/tb_opl3_reg_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_opl3_reg_wr_arbiter
// Two instances: a 2-requester arbiter for directed vectors and a
// 3-requester arbiter for grant rotation and randomized traffic against a
// cycle-level reference model (last-acceptance time + rotating priority).
// ---------------------------------------------------------------------------
module tb_opl3_reg_wr_arbiter;
    import opl3_pkg::*;

    localparam int GAP         = 4;
    localparam int N3          = 3;
    localparam int RAND_CYCLES = 10000;

    localparam opl3_reg_wr_t Z   = '0;
    localparam opl3_reg_wr_t P0  = '{valid: 1'b1, bank_num: 1'b0, address: 8'hB0, data: 8'h20};
    localparam opl3_reg_wr_t P0N = '{valid: 1'b0, bank_num: 1'b0, address: 8'hB0, data: 8'h20};
    localparam opl3_reg_wr_t P1  = '{valid: 1'b1, bank_num: 1'b1, address: 8'hA5, data: 8'h3C};
    localparam opl3_reg_wr_t P1N = '{valid: 1'b0, bank_num: 1'b1, address: 8'hA5, data: 8'h3C};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst2;
    opl3_reg_wr_t req2 [2];
    logic [1:0]   rdy2;
    opl3_reg_wr_t out2;
    logic         idle2;

    logic         rst3;
    opl3_reg_wr_t req3 [N3];
    logic [N3-1:0] rdy3;
    opl3_reg_wr_t out3;
    logic         idle3;

    opl3_reg_wr_arbiter #(.NUM_REQ(2), .MIN_GAP_CYCLES(GAP)) u_dut2 (
        .clk(clk), .reset(rst2), .req_wr(req2),
        .req_ready(rdy2), .opl3_reg_wr(out2), .idle(idle2)
    );

    opl3_reg_wr_arbiter #(.NUM_REQ(N3), .MIN_GAP_CYCLES(GAP)) u_dut3 (
        .clk(clk), .reset(rst3), .req_wr(req3),
        .req_ready(rdy3), .opl3_reg_wr(out3), .idle(idle3)
    );

    typedef struct {
        logic         rst;
        logic [1:0]   v;
        logic [1:0]   exp_rdy;
        opl3_reg_wr_t exp_out;
        logic         exp_idle;
    } vec_t;

    vec_t tbl [18];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at t=%0t: got %h required %h", name, $time, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic [1:0] v, input logic [1:0] r,
                                input opl3_reg_wr_t o, input logic idl);
        vec_t x;
        x.rst = rst; x.v = v; x.exp_rdy = r; x.exp_out = o; x.exp_idle = idl;
        return x;
    endfunction

    function automatic opl3_reg_wr_t rnd_pl(input logic v);
        opl3_reg_wr_t p;
        p.valid    = v;
        p.bank_num = 1'($urandom);
        p.address  = 8'($urandom);
        p.data     = 8'($urandom);
        return p;
    endfunction

    task automatic reset2();
        rst2 = 1'b1;
        req2[0] = P0N; req2[1] = P1N;
        next_cycle();
        next_cycle();
        rst2 = 1'b0;
    endtask

    task automatic reset3();
        rst3 = 1'b1;
        for (int i = 0; i < N3; i++) req3[i] = rnd_pl(1'b0);
        next_cycle();
        next_cycle();
        rst3 = 1'b0;
    endtask

    // reference model state for random traffic
    opl3_reg_wr_t m_out;
    int           m_ptr;
    int           m_last;
    int           last_pulse;
    int           g;
    logic [N3-1:0] exp_r;
    logic         exp_idle;
    opl3_reg_wr_t old_req [N3];
    logic [1:0]   e2;

    initial begin
        // rows: rst, valid{1,0}, ready{1,0}, output, idle
        tbl[0]  = mk(1'b0, 2'b00, 2'b00, Z,   1'b1);
        tbl[1]  = mk(1'b0, 2'b01, 2'b01, Z,   1'b1);
        tbl[2]  = mk(1'b0, 2'b11, 2'b00, P0,  1'b0);
        tbl[3]  = mk(1'b0, 2'b11, 2'b00, P0N, 1'b0);
        tbl[4]  = mk(1'b0, 2'b11, 2'b00, P0N, 1'b0);
        tbl[5]  = mk(1'b0, 2'b11, 2'b10, P0N, 1'b1);
        tbl[6]  = mk(1'b0, 2'b01, 2'b00, P1,  1'b0);
        tbl[7]  = mk(1'b0, 2'b01, 2'b00, P1N, 1'b0);
        tbl[8]  = mk(1'b0, 2'b01, 2'b00, P1N, 1'b0);
        tbl[9]  = mk(1'b0, 2'b01, 2'b01, P1N, 1'b1);
        tbl[10] = mk(1'b1, 2'b10, 2'b00, P0,  1'b0);
        tbl[11] = mk(1'b0, 2'b10, 2'b10, Z,   1'b1);
        tbl[12] = mk(1'b0, 2'b00, 2'b00, P1,  1'b0);
        tbl[13] = mk(1'b0, 2'b00, 2'b00, P1N, 1'b0);
        tbl[14] = mk(1'b0, 2'b00, 2'b00, P1N, 1'b0);
        tbl[15] = mk(1'b1, 2'b01, 2'b00, P1N, 1'b1);
        tbl[16] = mk(1'b0, 2'b01, 2'b01, Z,   1'b1);
        tbl[17] = mk(1'b0, 2'b00, 2'b00, P0,  1'b0);

        rst3 = 1'b1;
        for (int i = 0; i < N3; i++) req3[i] = Z;
        reset2();

        // ---- table-driven vectors on the 2-requester instance ----
        for (int r = 0; r < 18; r++) begin
            rst2 = tbl[r].rst;
            req2[0] = P0; req2[0].valid = tbl[r].v[0];
            req2[1] = P1; req2[1].valid = tbl[r].v[1];
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), 32'(rdy2), 32'(tbl[r].exp_rdy));
            chk($sformatf("tbl%0d_out", r), 32'(out2), 32'(tbl[r].exp_out));
            chk($sformatf("tbl%0d_idle", r), 32'(idle2), 32'(tbl[r].exp_idle));
            next_cycle();
        end

        // ---- single write at cycle 10 after reset ----
        reset2();
        chk("single_reset_out", 32'(out2), 32'(Z));
        for (int c = 2; c <= 14; c++) begin
            req2[0] = P0; req2[0].valid = (c == 10);
            req2[1] = P1N;
            @(negedge clk);
            chk($sformatf("single_c%0d_ready", c), 32'(rdy2), (c == 10) ? 32'd1 : 32'd0);
            chk($sformatf("single_c%0d_outv", c), 32'(out2.valid), 32'(c == 11));
            if (c == 11) chk("single_payload", 32'(out2), 32'(P0));
            next_cycle();
        end

        // ---- two requesters contend at cycle 10, pointer back to 0 after ----
        reset2();
        for (int c = 2; c <= 22; c++) begin
            req2[0] = P0; req2[0].valid = (c == 10) || (c == 20);
            req2[1] = P1; req2[1].valid = (c >= 10 && c <= 14) || (c >= 20);
            e2 = (c == 10 || c == 20) ? 2'b01 : (c == 14) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk($sformatf("pair_c%0d_ready", c), 32'(rdy2), 32'(e2));
            if (c == 11 || c == 21) chk($sformatf("pair_c%0d_out", c), 32'(out2), 32'(P0));
            else if (c == 15)       chk("pair_c15_out", 32'(out2), 32'(P1));
            else                    chk($sformatf("pair_c%0d_outv", c), 32'(out2.valid), 32'd0);
            next_cycle();
        end

        // ---- req1 alone for 20 cycles from cycle 5 ----
        reset2();
        last_pulse = -1000;
        for (int c = 2; c <= 28; c++) begin
            req2[0] = P0N;
            req2[1] = P1; req2[1].valid = (c >= 5 && c <= 24);
            @(negedge clk);
            chk($sformatf("solo_c%0d_ready", c), 32'(rdy2),
                (c >= 5 && c <= 24 && ((c - 5) % GAP) == 0) ? 32'd2 : 32'd0);
            if (out2.valid) begin
                chk($sformatf("solo_c%0d_gap", c), 32'(c - last_pulse >= GAP), 32'd1);
                chk($sformatf("solo_c%0d_out", c), 32'(out2), 32'(P1));
                last_pulse = c;
            end
            next_cycle();
        end
        rst2 = 1'b1;

        // ---- three requesters all valid: grants rotate 0,1,2,... ----
        reset3();
        for (int i = 0; i < N3; i++) req3[i] = rnd_pl(1'b1);
        for (int c = 2; c <= 31; c++) begin
            @(negedge clk);
            chk($sformatf("rot_c%0d_onehot", c), 32'($onehot0(rdy3)), 32'd1);
            chk($sformatf("rot_c%0d_ready", c), 32'(rdy3),
                (((c - 2) % GAP) == 0) ? (32'd1 << (((c - 2) / GAP) % N3)) : 32'd0);
            next_cycle();
        end

        // ---- randomized traffic against the reference model ----
        reset3();
        m_out = '0; m_ptr = 0; m_last = -1000; last_pulse = -1000;
        for (int i = 0; i < N3; i++) req3[i] = rnd_pl(1'($urandom));
        for (int t = 0; t < RAND_CYCLES; t++) begin
            exp_r = '0;
            g = -1;
            if (!rst3 && (t - m_last >= GAP)) begin
                for (int k = 0; k < N3; k++) begin
                    if (g < 0 && req3[(m_ptr + k) % N3].valid) g = (m_ptr + k) % N3;
                end
            end
            if (g >= 0) exp_r[g] = 1'b1;
            exp_idle = (t - m_last >= GAP) && !m_out.valid;

            @(negedge clk);
            chk("rand_ready", 32'(rdy3), 32'(exp_r));
            chk("rand_out", 32'(out3), 32'(m_out));
            chk("rand_idle", 32'(idle3), 32'(exp_idle));
            chk("rand_onehot", 32'($onehot0(rdy3)), 32'd1);
            if (out3.valid) begin
                chk("rand_pulse_gap", 32'(t - last_pulse >= GAP), 32'd1);
                last_pulse = t;
            end
            next_cycle();

            if (rst3) begin
                m_out = '0; m_ptr = 0; m_last = -1000; last_pulse = -1000;
            end else if (g >= 0) begin
                m_out = req3[g];
                m_last = t;
                m_ptr = (g + 1) % N3;
            end else begin
                m_out.valid = 1'b0;
            end

            for (int i = 0; i < N3; i++) begin
                old_req[i] = req3[i];
                if (exp_r[i]) req3[i] = rnd_pl(1'($urandom));
                else if (!req3[i].valid && $urandom_range(0, 2) == 0) req3[i] = rnd_pl(1'b1);
                assert (!(old_req[i].valid && !exp_r[i]) || req3[i] == old_req[i])
                    else $error("requester %0d changed a pending request", i);
            end
            rst3 = ($urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
